// File: rtl/spi_slave_responder.sv
// rtl/spi_slave_responder.sv - oversampled SPI responder with byte-level TX/RX handshake
module spi_slave_responder #(
    parameter int unsigned SPI_MODE    = 3,
    parameter logic [7:0]  DUMMY_BYTE  = 8'hFF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_DV,
    output logic [7:0] o_Byte_Count,
    output logic       o_TX_Underrun,
    output logic       o_CS_Abort,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_CS_n,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO,
    output logic       o_SPI_MISO_En
);
    localparam int unsigned NS   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic        CPOL = ((SPI_MODE & 2) != 0);
    localparam logic        CPHA = ((SPI_MODE & 1) != 0);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

    logic [NS-1:0] sck_sync;
    logic [NS-1:0] cs_sync;
    logic [NS-1:0] mosi_sync;
    logic          sck_q;
    logic          cs_q;

    logic          sck_s;
    logic          cs_s;
    logic          mosi_s;
    logic          lead_edge;
    logic          trail_edge;
    logic          sample_edge;
    logic          shift_edge;
    logic          cs_fall;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    tx_shift;
    logic [7:0]    rx_shift;
    logic [7:0]    hold_reg;

    // Bring the asynchronous SPI pins into the i_Clk domain; idle levels on reset
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sck_sync  <= {NS{CPOL}};
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_q     <= CPOL;
            cs_q      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[NS-2:0], i_SPI_Clk};
            cs_sync   <= {cs_sync[NS-2:0], i_SPI_CS_n};
            mosi_sync <= {mosi_sync[NS-2:0], i_SPI_MOSI};
            sck_q     <= sck_sync[NS-1];
            cs_q      <= cs_sync[NS-1];
        end
    end

    assign sck_s       = sck_sync[NS-1];
    assign cs_s        = cs_sync[NS-1];
    assign mosi_s      = mosi_sync[NS-1];
    assign lead_edge   = (sck_s != CPOL) && (sck_q == CPOL);
    assign trail_edge  = (sck_s == CPOL) && (sck_q != CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign cs_fall     = cs_q && !cs_s;

    // MISO is always the top of the TX shifter, so it idles high after reset
    assign o_SPI_MISO = tx_shift[7];

    // Transaction FSM, holding register handshake and registered status pulses
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state         <= ST_IDLE;
            bit_cnt       <= 3'd0;
            tx_shift      <= 8'hFF;
            rx_shift      <= 8'h00;
            hold_reg      <= 8'h00;
            o_TX_Ready    <= 1'b1;
            o_RX_Byte     <= 8'h00;
            o_RX_DV       <= 1'b0;
            o_Byte_Count  <= 8'h00;
            o_TX_Underrun <= 1'b0;
            o_CS_Abort    <= 1'b0;
            o_SPI_MISO_En <= 1'b0;
        end else begin
            o_RX_DV       <= 1'b0;
            o_TX_Underrun <= 1'b0;
            o_CS_Abort    <= 1'b0;

            // An empty holding register accepts a new reply byte in any state
            if (i_TX_DV && o_TX_Ready) begin
                hold_reg   <= i_TX_Byte;
                o_TX_Ready <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    o_SPI_MISO_En <= 1'b0;
                    bit_cnt       <= 3'd0;
                    if (cs_fall) begin
                        o_Byte_Count <= 8'h00;
                        state        <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!o_TX_Ready) begin
                        // Full register: take the old byte; a same-cycle write refills it
                        tx_shift <= hold_reg;
                        if (i_TX_DV) begin
                            hold_reg   <= i_TX_Byte;
                            o_TX_Ready <= 1'b0;
                        end else begin
                            o_TX_Ready <= 1'b1;
                        end
                    end else begin
                        tx_shift      <= DUMMY_BYTE;
                        o_TX_Underrun <= 1'b1;
                    end
                    o_SPI_MISO_En <= 1'b1;
                    bit_cnt       <= 3'd0;
                    state         <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (cs_s) begin
                        o_SPI_MISO_En <= 1'b0;
                        o_CS_Abort    <= (bit_cnt != 3'd0);
                        bit_cnt       <= 3'd0;
                        state         <= ST_IDLE;
                    end else begin
                        // The first shift edge of a byte would skip past bit 7, which LOAD already presented
                        if (shift_edge && (bit_cnt != 3'd0)) begin
                            tx_shift <= {tx_shift[6:0], 1'b1};
                        end
                        if (sample_edge) begin
                            rx_shift <= {rx_shift[6:0], mosi_s};
                            if (bit_cnt == 3'd7) begin
                                o_RX_Byte    <= {rx_shift[6:0], mosi_s};
                                o_RX_DV      <= 1'b1;
                                o_Byte_Count <= o_Byte_Count + 8'd1;
                                bit_cnt      <= 3'd0;
                                state        <= ST_LOAD;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave_responder.sv
// tb/tb_spi_slave_responder.sv - directed self-checking bench for spi_slave_responder
module tb_spi_slave_responder;
    localparam int H = 12;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_byte    [4];
    logic       tx_dv      [4];
    logic       tx_ready   [4];
    logic [7:0] rx_byte    [4];
    logic       rx_dv      [4];
    logic [7:0] byte_count [4];
    logic       underrun   [4];
    logic       abort      [4];
    logic       sck        [4];
    logic       cs_n       [4];
    logic       mosi       [4];
    logic       miso       [4];
    logic       miso_en    [4];

    int         rxdv_cnt  [4] = '{0, 0, 0, 0};
    int         und_cnt   [4] = '{0, 0, 0, 0};
    int         abort_cnt [4] = '{0, 0, 0, 0};
    logic [7:0] rx_log    [64];

    logic [7:0] mtx [4];
    logic [7:0] mrx [4];
    int         und_last;
    int         pass_cnt  = 0;
    int         total_cnt = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_responder #(.SPI_MODE(g)) u_dut (
            .i_Clk         (clk),
            .i_Rst_L       (rst_n),
            .i_TX_Byte     (tx_byte[g]),
            .i_TX_DV       (tx_dv[g]),
            .o_TX_Ready    (tx_ready[g]),
            .o_RX_Byte     (rx_byte[g]),
            .o_RX_DV       (rx_dv[g]),
            .o_Byte_Count  (byte_count[g]),
            .o_TX_Underrun (underrun[g]),
            .o_CS_Abort    (abort[g]),
            .i_SPI_Clk     (sck[g]),
            .i_SPI_CS_n    (cs_n[g]),
            .i_SPI_MOSI    (mosi[g]),
            .o_SPI_MISO    (miso[g]),
            .o_SPI_MISO_En (miso_en[g])
        );
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rx_dv[k] === 1'b1) begin
                if (k == 3) rx_log[rxdv_cnt[3] % 64] = rx_byte[3];
                rxdv_cnt[k]++;
            end
            if (underrun[k] === 1'b1) und_cnt[k]++;
            if (abort[k] === 1'b1) abort_cnt[k]++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic hp();
        repeat (H) @(negedge clk);
    endtask

    task automatic load_tx(input int m, input logic [7:0] b);
        @(negedge clk);
        tx_byte[m] = b;
        tx_dv[m]   = 1'b1;
        @(negedge clk);
        tx_dv[m]   = 1'b0;
    endtask

    task automatic wait_ready(input int m);
        int n = 0;
        while (tx_ready[m] !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (tx_ready[m] !== 1'b1) begin
            total_cnt++;
            $display("FAIL wait_ready: tx_ready=%b after %0d cycles, required 1", tx_ready[m], n);
        end
    endtask

    task automatic wait_rxdv(input int m, input int target);
        int n = 0;
        while (rxdv_cnt[m] < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (rxdv_cnt[m] < target) begin
            total_cnt++;
            $display("FAIL wait_rxdv: count=%0d after %0d cycles, required %0d", rxdv_cnt[m], n, target);
        end
    endtask

    // Master side: CS low, nbytes from mtx (last one may be cut short), CS high
    task automatic spi_xfer(input int m, input int nbytes, input int last_bits);
        logic cpol;
        logic cpha;
        int   nb;
        logic [7:0] r;
        cpol = m[1];
        cpha = m[0];
        cs_n[m] = 1'b0;
        hp();
        for (int b = 0; b < nbytes; b++) begin
            nb = (b == nbytes - 1) ? last_bits : 8;
            r  = 8'h00;
            for (int i = 0; i < nb; i++) begin
                if (!cpha) begin
                    mosi[m] = mtx[b][7-i];
                    hp();
                    sck[m] = ~cpol;
                    r = {r[6:0], miso[m]};
                    if (b == nbytes - 1 && i == nb - 1) und_last = und_cnt[m];
                    hp();
                    sck[m] = cpol;
                end else begin
                    sck[m]  = ~cpol;
                    mosi[m] = mtx[b][7-i];
                    hp();
                    sck[m] = cpol;
                    r = {r[6:0], miso[m]};
                    if (b == nbytes - 1 && i == nb - 1) und_last = und_cnt[m];
                    hp();
                end
            end
            mrx[b] = r;
        end
        hp();
        cs_n[m] = 1'b1;
        hp();
        hp();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        total_cnt++; if (tx_ready[3] !== 1'b1) $display("FAIL rst_tx_ready: got %b, expected 1", tx_ready[3]); else pass_cnt++;
        total_cnt++; if (rx_byte[3] !== 8'h00) $display("FAIL rst_rx_byte: got %h, expected 00", rx_byte[3]); else pass_cnt++;
        total_cnt++; if (rx_dv[3] !== 1'b0) $display("FAIL rst_rx_dv: got %b, expected 0", rx_dv[3]); else pass_cnt++;
        total_cnt++; if (byte_count[3] !== 8'h00) $display("FAIL rst_byte_count: got %h, expected 00", byte_count[3]); else pass_cnt++;
        total_cnt++; if (underrun[3] !== 1'b0) $display("FAIL rst_underrun: got %b, expected 0", underrun[3]); else pass_cnt++;
        total_cnt++; if (abort[3] !== 1'b0) $display("FAIL rst_abort: got %b, expected 0", abort[3]); else pass_cnt++;
        total_cnt++; if (miso[3] !== 1'b1) $display("FAIL rst_miso: got %b, expected 1", miso[3]); else pass_cnt++;
        total_cnt++; if (miso_en[3] !== 1'b0) $display("FAIL rst_miso_en: got %b, expected 0", miso_en[3]); else pass_cnt++;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic();
        int r0;
        int u0;
        load_tx(3, 8'hA5);
        total_cnt++; if (tx_ready[3] !== 1'b0) $display("FAIL basic_ready_low: got %b, expected 0", tx_ready[3]); else pass_cnt++;
        r0 = rxdv_cnt[3];
        u0 = und_cnt[3];
        mtx[0] = 8'hCC;
        spi_xfer(3, 1, 8);
        total_cnt++; if (rxdv_cnt[3] - r0 !== 1) $display("FAIL basic_rxdv_pulses: got %0d, expected 1", rxdv_cnt[3] - r0); else pass_cnt++;
        total_cnt++; if (rx_byte[3] !== 8'hCC) $display("FAIL basic_rx_byte: got %h, expected cc", rx_byte[3]); else pass_cnt++;
        total_cnt++; if (mrx[0] !== 8'hA5) $display("FAIL basic_master_rx: got %h, expected a5", mrx[0]); else pass_cnt++;
        total_cnt++; if (byte_count[3] !== 8'd1) $display("FAIL basic_byte_count: got %0d, expected 1", byte_count[3]); else pass_cnt++;
        total_cnt++; if (tx_ready[3] !== 1'b1) $display("FAIL basic_ready_high: got %b, expected 1", tx_ready[3]); else pass_cnt++;
        total_cnt++; if (und_last - u0 !== 0) $display("FAIL basic_no_underrun: got %0d, expected 0", und_last - u0); else pass_cnt++;
    endtask

    task automatic test_underrun();
        int u0;
        u0 = und_cnt[3];
        mtx[0] = 8'h3C;
        spi_xfer(3, 1, 8);
        total_cnt++; if (und_last - u0 !== 1) $display("FAIL underrun_pulses: got %0d, expected 1", und_last - u0); else pass_cnt++;
        total_cnt++; if (mrx[0] !== 8'hFF) $display("FAIL underrun_master_rx: got %h, expected ff", mrx[0]); else pass_cnt++;
        total_cnt++; if (rx_byte[3] !== 8'h3C) $display("FAIL underrun_rx_byte: got %h, expected 3c", rx_byte[3]); else pass_cnt++;
    endtask

    task automatic test_abort();
        int a0;
        int r0;
        a0 = abort_cnt[3];
        r0 = rxdv_cnt[3];
        mtx[0] = 8'hF0;
        spi_xfer(3, 1, 5);
        total_cnt++; if (abort_cnt[3] - a0 !== 1) $display("FAIL abort_pulses: got %0d, expected 1", abort_cnt[3] - a0); else pass_cnt++;
        total_cnt++; if (rxdv_cnt[3] - r0 !== 0) $display("FAIL abort_no_rxdv: got %0d, expected 0", rxdv_cnt[3] - r0); else pass_cnt++;
        total_cnt++; if (rx_byte[3] !== 8'h3C) $display("FAIL abort_rx_byte_kept: got %h, expected 3c", rx_byte[3]); else pass_cnt++;
        total_cnt++; if (miso_en[3] !== 1'b0) $display("FAIL abort_miso_en: got %b, expected 0", miso_en[3]); else pass_cnt++;
        total_cnt++; if (byte_count[3] !== 8'd0) $display("FAIL abort_byte_count: got %0d, expected 0", byte_count[3]); else pass_cnt++;
        load_tx(3, 8'hC3);
        mtx[0] = 8'h5A;
        spi_xfer(3, 1, 8);
        total_cnt++; if (rx_byte[3] !== 8'h5A) $display("FAIL abort_next_rx: got %h, expected 5a", rx_byte[3]); else pass_cnt++;
        total_cnt++; if (mrx[0] !== 8'hC3) $display("FAIL abort_next_master_rx: got %h, expected c3", mrx[0]); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int r0;
        int u0;
        mtx[0] = 8'h01;
        mtx[1] = 8'h02;
        mtx[2] = 8'h03;
        load_tx(3, 8'h11);
        r0 = rxdv_cnt[3];
        u0 = und_cnt[3];
        fork
            spi_xfer(3, 3, 8);
            begin
                wait_ready(3);
                load_tx(3, 8'h22);
                wait_rxdv(3, r0 + 1);
                wait_ready(3);
                load_tx(3, 8'h33);
            end
        join
        total_cnt++; if (rxdv_cnt[3] - r0 !== 3) $display("FAIL b2b_rxdv_pulses: got %0d, expected 3", rxdv_cnt[3] - r0); else pass_cnt++;
        total_cnt++; if (rx_log[r0 % 64] !== 8'h01) $display("FAIL b2b_rx0: got %h, expected 01", rx_log[r0 % 64]); else pass_cnt++;
        total_cnt++; if (rx_log[(r0 + 1) % 64] !== 8'h02) $display("FAIL b2b_rx1: got %h, expected 02", rx_log[(r0 + 1) % 64]); else pass_cnt++;
        total_cnt++; if (rx_log[(r0 + 2) % 64] !== 8'h03) $display("FAIL b2b_rx2: got %h, expected 03", rx_log[(r0 + 2) % 64]); else pass_cnt++;
        total_cnt++; if (mrx[0] !== 8'h11) $display("FAIL b2b_master0: got %h, expected 11", mrx[0]); else pass_cnt++;
        total_cnt++; if (mrx[1] !== 8'h22) $display("FAIL b2b_master1: got %h, expected 22", mrx[1]); else pass_cnt++;
        total_cnt++; if (mrx[2] !== 8'h33) $display("FAIL b2b_master2: got %h, expected 33", mrx[2]); else pass_cnt++;
        total_cnt++; if (byte_count[3] !== 8'd3) $display("FAIL b2b_byte_count: got %0d, expected 3", byte_count[3]); else pass_cnt++;
        total_cnt++; if (und_last - u0 !== 0) $display("FAIL b2b_no_underrun: got %0d, expected 0", und_last - u0); else pass_cnt++;
    endtask

    task automatic test_modes();
        int r0;
        for (int m = 0; m < 3; m++) begin
            load_tx(m, 8'h81);
            r0 = rxdv_cnt[m];
            mtx[0] = 8'h7E;
            spi_xfer(m, 1, 8);
            total_cnt++; if (rx_byte[m] !== 8'h7E) $display("FAIL mode%0d_rx_byte: got %h, expected 7e", m, rx_byte[m]); else pass_cnt++;
            total_cnt++; if (mrx[0] !== 8'h81) $display("FAIL mode%0d_master_rx: got %h, expected 81", m, mrx[0]); else pass_cnt++;
            total_cnt++; if (rxdv_cnt[m] - r0 !== 1) $display("FAIL mode%0d_rxdv: got %0d, expected 1", m, rxdv_cnt[m] - r0); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        int r0;
        load_tx(3, 8'h55);
        cs_n[3] = 1'b0;
        hp();
        for (int i = 0; i < 3; i++) begin
            sck[3]  = 1'b0;
            mosi[3] = 1'b1;
            hp();
            sck[3] = 1'b1;
            hp();
        end
        total_cnt++; if (miso_en[3] !== 1'b1) $display("FAIL mid_miso_en_active: got %b, expected 1", miso_en[3]); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (miso_en[3] !== 1'b0) $display("FAIL mid_rst_miso_en: got %b, expected 0", miso_en[3]); else pass_cnt++;
        total_cnt++; if (tx_ready[3] !== 1'b1) $display("FAIL mid_rst_tx_ready: got %b, expected 1", tx_ready[3]); else pass_cnt++;
        total_cnt++; if (rx_byte[3] !== 8'h00) $display("FAIL mid_rst_rx_byte: got %h, expected 00", rx_byte[3]); else pass_cnt++;
        total_cnt++; if (byte_count[3] !== 8'h00) $display("FAIL mid_rst_byte_count: got %h, expected 00", byte_count[3]); else pass_cnt++;
        total_cnt++; if (miso[3] !== 1'b1) $display("FAIL mid_rst_miso: got %b, expected 1", miso[3]); else pass_cnt++;
        cs_n[3] = 1'b1;
        sck[3]  = 1'b1;
        mosi[3] = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        load_tx(3, 8'h69);
        r0 = rxdv_cnt[3];
        mtx[0] = 8'h96;
        spi_xfer(3, 1, 8);
        total_cnt++; if (rx_byte[3] !== 8'h96) $display("FAIL mid_after_rx_byte: got %h, expected 96", rx_byte[3]); else pass_cnt++;
        total_cnt++; if (mrx[0] !== 8'h69) $display("FAIL mid_after_master_rx: got %h, expected 69", mrx[0]); else pass_cnt++;
        total_cnt++; if (byte_count[3] !== 8'd1) $display("FAIL mid_after_byte_count: got %0d, expected 1", byte_count[3]); else pass_cnt++;
        total_cnt++; if (rxdv_cnt[3] - r0 !== 1) $display("FAIL mid_after_rxdv: got %0d, expected 1", rxdv_cnt[3] - r0); else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sck[k]     = (k >= 2);
            cs_n[k]    = 1'b1;
            mosi[k]    = 1'b0;
            tx_dv[k]   = 1'b0;
            tx_byte[k] = 8'h00;
        end
        test_reset();
        test_basic();
        test_underrun();
        test_abort();
        test_back_to_back();
        test_modes();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
- SPI peripheral (responder) for the far end of the mode-3 SPI master link.
- Oversamples SCK, CS_n and MOSI in the system clock domain and deserialises MOSI bytes MSB-first.
- Serialises a preloaded reply byte on MISO, full-duplex.
- Presents a byte-level valid/ready interface to local control logic, plus per-transaction byte count and error pulses.

Parameters:
- SPI_MODE, 3, SPI mode 0..3. CPOL = SPI_MODE[1], CPHA = SPI_MODE[0].
- DUMMY_BYTE, 8'hFF, byte shifted out when no reply byte is loaded (underrun).
- SYNC_STAGES, 2, synchroniser flops on SCK, CS_n and MOSI (minimum 2).

Ports:
- i_Clk  in  1  system clock.
- i_Rst_L  in  1  asynchronous, active-low reset.
- i_TX_Byte  in  8  reply byte for MISO.
- i_TX_DV  in  1  one-cycle pulse; i_TX_Byte valid. Accepted only when o_TX_Ready=1.
- o_TX_Ready  out  1  holding register empty; a new reply byte may be written.
- o_RX_Byte  out  8  last complete byte received on MOSI.
- o_RX_DV  out  1  one-cycle pulse; o_RX_Byte updated.
- o_Byte_Count  out  8  completed bytes in the current transaction.
- o_TX_Underrun  out  1  one-cycle pulse; DUMMY_BYTE was loaded instead of a user byte.
- o_CS_Abort  out  1  one-cycle pulse; CS_n rose with a partial byte in progress.
- i_SPI_Clk  in  1  SCK from master (asynchronous).
- i_SPI_CS_n  in  1  chip select, active-low (asynchronous).
- i_SPI_MOSI  in  1  master data out (asynchronous).
- o_SPI_MISO  out  1  responder data out.
- o_SPI_MISO_En  out  1  MISO output enable; 1 only while synced CS_n=0.

Behaviour:
- Reset (i_Rst_L=0, asynchronous):
  - o_TX_Ready=1; o_RX_Byte=0; o_RX_DV=0; o_Byte_Count=0; o_TX_Underrun=0; o_CS_Abort=0; o_SPI_MISO=1; o_SPI_MISO_En=0.
  - Holding register empty; synchroniser flops preset to idle (SCK=CPOL, CS_n=1).
- Synchronisation:
  - SCK, CS_n and MOSI each pass SYNC_STAGES flops; one extra flop on SCK and CS_n for edge detection.
  - All SPI events lag the pins by SYNC_STAGES+1 i_Clk cycles.
  - Required: SCK half-period >= 4 i_Clk cycles.
- Edges:
  - Leading edge = SCK transition away from CPOL; trailing edge = transition back to CPOL.
  - CPHA=0: sample MOSI on leading, shift MISO on trailing.
  - CPHA=1: shift MISO on leading, sample MOSI on trailing.
- State machine: IDLE, LOAD, SHIFT.
  - IDLE: CS_n high, MISO_En=0, bit counter=0.
    - Synced CS_n falling -> LOAD; o_Byte_Count cleared to 0.
  - LOAD (1 cycle):
    - If holding register is full: copy it to the shift register, set o_TX_Ready=1.
    - Otherwise: load DUMMY_BYTE and pulse o_TX_Underrun.
    - o_SPI_MISO = shift[7]; MISO_En=1. Go to SHIFT.
  - SHIFT:
    - Shift edge: MISO advances to the next bit.
      - CPHA=1: the first leading edge of each byte does not advance; bit 7 is already presented.
    - Sample edge: rx shift <= {rx[6:0], MOSI}; bit counter +1.
    - On the 8th sample:
      - Next cycle: o_RX_Byte <= assembled byte, o_RX_DV=1 for one cycle, o_Byte_Count +1 (wraps 255->0).
      - Bit counter -> 0; state -> LOAD for the next byte of a multi-byte transaction.
    - Synced CS_n rising -> IDLE, MISO_En=0 next cycle.
      - If bit counter != 0: pulse o_CS_Abort; partial byte discarded; no RX_DV; o_Byte_Count holds.
- TX handshake:
  - i_TX_DV while o_TX_Ready=1: capture i_TX_Byte, o_TX_Ready=0 next cycle.
  - i_TX_DV while o_TX_Ready=0: ignored; holding register unchanged.
  - i_TX_DV in the same cycle as LOAD consuming the holding register: LOAD takes the old byte, the new byte is captured, o_TX_Ready stays 0.
  - i_TX_DV in the same cycle as LOAD with the register empty: underrun is declared, then the byte is captured for the next LOAD.
- Holding register survives CS_n deassertion; an unconsumed byte is used by the next transaction.
- CS_n falling while already in SHIFT cannot occur; CS_n glitches shorter than the synchroniser depth are filtered only by the sampling grid.
- Reset asserted mid-transfer: all state returns to reset values immediately; MISO_En drops asynchronously.

Test Plan:
- Mode 3, slave preloaded 8'hA5, master sends 8'hCC, 12 i_Clk per half-bit -> one o_RX_DV pulse, o_RX_Byte=8'hCC, master receives 8'hA5, o_Byte_Count=1, o_TX_Ready returns 1 at LOAD.
- No reply loaded, master sends 8'h3C -> o_TX_Underrun pulses once at CS fall, MISO shifts 8'hFF, o_RX_Byte=8'h3C.
- 3-byte transaction, slave loads 8'h11, 8'h22, 8'h33 via TX_DV after each RX_DV, master sends 8'h01, 8'h02, 8'h03 -> three RX_DV pulses with matching bytes, master reads 11/22/33, o_Byte_Count=3, no underrun.
- Master drops CS_n after 5 bits of 8'hF0 -> o_CS_Abort pulse, no RX_DV, o_RX_Byte unchanged, MISO_En=0; next full transfer of 8'h5A is received correctly.
- Loop over SPI_MODE 0/1/2, slave reply 8'h81, master 8'h7E -> both bytes exchanged correctly in every mode.
- i_Rst_L pulsed low mid-byte -> all outputs at reset values within the same cycle; o_TX_Ready=1; a subsequent transfer works with the bit counter starting from 0.
